btb_predictor: RTL

- Parametrised branch target buffer with n-bit saturating direction counters. It generalises the single-entry V/TAG/TA/T branch-cache record to a direct-mapped array of ENTRIES records.
- IF stage performs a combinational lookup on the fetch PC, producing hit, predicted direction and predicted target for PC-source selection.
- MEM stage writes back resolved branch/jump outcomes through a one-cycle update port.
- Supports a whole-table flush for fence/context events.

---
 rtl/btb_predictor.sv | 97 +++++++++
 1 files changed

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer. The IF-stage lookup is combinational.
// The MEM stage trains an entry in one cycle through saturating direction counters.
module btb_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 6,
  parameter int CNT_W   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lk_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            flush
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  // Weakly taken is the MSB alone; this form also works for CNT_W = 1.
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_MAX ^ (CNT_MAX >> 1);

  logic             v_q   [ENTRIES];
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [XLEN-1:0]  ta_q  [ENTRIES];
  logic [CNT_W-1:0] cnt_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_hit;
  logic             upd_we;
  logic [XLEN-1:0]  ta_d;
  logic [CNT_W-1:0] cnt_d;
  logic             unused_pc_bits;

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_pc_bits = ^{lk_pc, upd_pc};

  // Lookup sees pre-edge contents only; a same-cycle update is never bypassed.
  assign pred_hit    = v_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit && cnt_q[lk_idx][CNT_W-1];
  assign pred_target = pred_hit ? ta_q[lk_idx] : '0;

  assign upd_hit = v_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    upd_we = 1'b0;
    ta_d   = ta_q[upd_idx];
    cnt_d  = cnt_q[upd_idx];
    if (upd_valid && !flush) begin
      if (upd_hit) begin
        upd_we = 1'b1;
        if (upd_taken) begin
          ta_d  = upd_target;
          cnt_d = (cnt_q[upd_idx] == CNT_MAX) ? CNT_MAX : cnt_q[upd_idx] + 1'b1;
        end else begin
          cnt_d = (cnt_q[upd_idx] == '0) ? '0 : cnt_q[upd_idx] - 1'b1;
        end
      end else if (upd_taken) begin
        upd_we = 1'b1;
        ta_d   = upd_target;
        cnt_d  = CNT_WEAK;
      end
    end
  end

  // NOTE: the table is built from flops rather than SRAM, so the async reset clears every entry.
  // NOTE: state updates use non-blocking assignments so all entries sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        v_q[i]   <= 1'b0;
        tag_q[i] <= '0;
        ta_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        v_q[i] <= 1'b0;
      end
    end else if (upd_we) begin
      v_q[upd_idx]   <= 1'b1;
      tag_q[upd_idx] <= upd_tag;
      ta_q[upd_idx]  <= ta_d;
      cnt_q[upd_idx] <= cnt_d;
    end
  end

endmodule
